llr_combine_buf: RTL and testbench

//  Downstream of postFFT: captures the 864 descrambled PBCH channel LLRs into two banks (4 LLRs/word).

---
 rtl/llr_combine_buf.sv | 137 +++++++++++++
 tb/tb_llr_combine_buf.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/llr_combine_buf.sv
// Two-bank PBCH LLR capture buffer: bank2 repeats are soft-combined into bank1
// with a saturating add, and the result is then served to the polar decoder.
module llr_combine_buf #(
  parameter int LLR_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int BANK1_WORDS = 128,
  parameter int BANK2_WORDS = 88
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [LLR_WIDTH-1:0] llrs,
  input  logic [ADDR_WIDTH-1:0]       llr_mem_w_addr,
  input  logic [1:0]                  mem_llr_slct,
  input  logic                        mem_1_w_enable,
  input  logic                        mem_2_w_enable,
  input  logic                        llr_done,
  input  logic                        dec_rd_en,
  input  logic [ADDR_WIDTH-1:0]       dec_rd_addr,
  output logic [4*LLR_WIDTH-1:0]      dec_rd_data,
  output logic                        dec_rd_vld,
  output logic                        dec_start,
  output logic                        buf_ready,
  output logic                        wr_err
);

  localparam int WORD_W = 4 * LLR_WIDTH;
  localparam logic [ADDR_WIDTH:0] B1_LIM = (ADDR_WIDTH+1)'(BANK1_WORDS);
  localparam logic [ADDR_WIDTH:0] B2_LIM = (ADDR_WIDTH+1)'(BANK2_WORDS);
  localparam logic signed [LLR_WIDTH:0] SAT_MAX = {2'b00, {(LLR_WIDTH-1){1'b1}}};
  localparam logic signed [LLR_WIDTH:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {FILL, COMBINE, READY} state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] cnt;

  logic [WORD_W-1:0] bank1 [BANK1_WORDS];
  logic [WORD_W-1:0] bank2 [BANK2_WORDS];

  logic [WORD_W-1:0]     rd1_p0, rd2_p0;
  logic [ADDR_WIDTH-1:0] waddr_p0;
  logic                  vld_p0;
  logic [WORD_W-1:0]     comb_word;

  logic wr_any, wr_accept, wr1_ok, wr2_ok, err_now, issue;

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [LLR_WIDTH-1:0] sat_add(
    input logic signed [LLR_WIDTH-1:0] a,
    input logic signed [LLR_WIDTH-1:0] b
  );
    logic signed [LLR_WIDTH:0] s;
    s = (LLR_WIDTH+1)'(a) + (LLR_WIDTH+1)'(b);
    if (s > SAT_MAX)      sat_add = SAT_MAX[LLR_WIDTH-1:0];
    else if (s < SAT_MIN) sat_add = SAT_MIN[LLR_WIDTH-1:0];
    else                  sat_add = s[LLR_WIDTH-1:0];
  endfunction

  always_comb begin
    wr_any    = mem_1_w_enable | mem_2_w_enable;
    wr_accept = (state == FILL) || (state == READY);
    wr1_ok    = mem_1_w_enable && wr_accept && ({1'b0, llr_mem_w_addr} < B1_LIM);
    wr2_ok    = mem_2_w_enable && wr_accept && ({1'b0, llr_mem_w_addr} < B2_LIM);
    err_now   = (wr_any && (state == COMBINE)) ||
                (mem_2_w_enable && ({1'b0, llr_mem_w_addr} >= B2_LIM));
    issue     = (state == COMBINE) && (cnt < B2_LIM);
  end

  always_comb begin
    comb_word = '0;
    for (int l = 0; l < 4; l++)
      comb_word[l*LLR_WIDTH +: LLR_WIDTH] =
        sat_add(rd1_p0[l*LLR_WIDTH +: LLR_WIDTH], rd2_p0[l*LLR_WIDTH +: LLR_WIDTH]);
  end

  // Stage p0: bank read during COMBINE; the following edge writes the sum back.
  always_ff @(posedge clk) begin
    if (wr1_ok)
      bank1[llr_mem_w_addr][mem_llr_slct*LLR_WIDTH +: LLR_WIDTH] <= llrs;
    else if (vld_p0)
      bank1[waddr_p0] <= comb_word;
    if (wr2_ok)
      bank2[llr_mem_w_addr][mem_llr_slct*LLR_WIDTH +: LLR_WIDTH] <= llrs;
    if (issue) begin
      rd1_p0   <= bank1[cnt[ADDR_WIDTH-1:0]];
      rd2_p0   <= bank2[cnt[ADDR_WIDTH-1:0]];
      waddr_p0 <= cnt[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      cnt         <= '0;
      vld_p0      <= 1'b0;
      dec_start   <= 1'b0;
      buf_ready   <= 1'b0;
      wr_err      <= 1'b0;
      dec_rd_vld  <= 1'b0;
      dec_rd_data <= '0;
    end else begin
      dec_start  <= 1'b0;
      dec_rd_vld <= 1'b0;
      vld_p0     <= issue;
      if (err_now) wr_err <= 1'b1;
      unique case (state)
        FILL: begin
          if (llr_done) begin
            state <= COMBINE;
            cnt   <= '0;
          end
        end
        COMBINE: begin
          if (issue) begin
            cnt <= cnt + 1'b1;
          end else begin
            state     <= READY;
            buf_ready <= 1'b1;
            dec_start <= 1'b1;
          end
        end
        READY: begin
          if (dec_rd_en) begin
            dec_rd_vld  <= 1'b1;
            dec_rd_data <= ({1'b0, dec_rd_addr} < B1_LIM) ? bank1[dec_rd_addr] : '0;
          end
          if (wr_any) begin
            state     <= FILL;
            buf_ready <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_combine_buf.sv
// Directed bench for llr_combine_buf: LLR model of both banks, scoreboard of
// expected read words pushed on each read request and popped on dec_rd_vld.
module tb_llr_combine_buf;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] llrs = '0;
  logic [6:0]        llr_mem_w_addr = '0;
  logic [1:0]        mem_llr_slct = '0;
  logic              mem_1_w_enable = 1'b0, mem_2_w_enable = 1'b0, llr_done = 1'b0;
  logic              dec_rd_en = 1'b0;
  logic [6:0]        dec_rd_addr = '0;
  logic [31:0]       dec_rd_data;
  logic              dec_rd_vld, dec_start, buf_ready, wr_err;

  llr_combine_buf dut (
    .clk(clk), .rst(rst), .llrs(llrs), .llr_mem_w_addr(llr_mem_w_addr),
    .mem_llr_slct(mem_llr_slct), .mem_1_w_enable(mem_1_w_enable),
    .mem_2_w_enable(mem_2_w_enable), .llr_done(llr_done), .dec_rd_en(dec_rd_en),
    .dec_rd_addr(dec_rd_addr), .dec_rd_data(dec_rd_data), .dec_rd_vld(dec_rd_vld),
    .dec_start(dec_start), .buf_ready(buf_ready), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [7:0] m1 [128][4];
  logic signed [7:0] m2 [88][4];
  logic [31:0] sb [$];
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int a);
    return {m1[a][3], m1[a][2], m1[a][1], m1[a][0]};
  endfunction

  task automatic apply_combine();
    for (int a = 0; a < 88; a++)
      for (int l = 0; l < 4; l++) begin
        int s;
        s = int'(m1[a][l]) + int'(m2[a][l]);
        if (s > 127) s = 127;
        if (s < -127) s = -127;
        m1[a][l] = 8'(s);
      end
  endtask

  task automatic idle();
    mem_1_w_enable = 1'b0; mem_2_w_enable = 1'b0; llr_done = 1'b0; dec_rd_en = 1'b0;
  endtask

  task automatic wr(input bit b1, input bit b2, input int a, input int lane,
                    input int val, input bit done);
    mem_1_w_enable = b1; mem_2_w_enable = b2; llr_done = done;
    llr_mem_w_addr = 7'(a); mem_llr_slct = 2'(lane); llrs = 8'(val);
    if (b1 && a < 128) m1[a][lane] = 8'(val);
    if (b2 && a < 88)  m2[a][lane] = 8'(val);
    @(negedge clk);
  endtask

  task automatic rd(input int a);
    logic [31:0] e;
    mem_1_w_enable = 1'b0; mem_2_w_enable = 1'b0; llr_done = 1'b0;
    dec_rd_en = 1'b1; dec_rd_addr = 7'(a);
    sb.push_back(mword(a));
    @(negedge clk);
    chk($sformatf("rd_vld_%0d", a), 32'(dec_rd_vld), 32'd1);
    e = sb.pop_front();
    if (dec_rd_vld) chk($sformatf("rd_data_%0d", a), dec_rd_data, e);
  endtask

  // Counts negedges after the llr_done sampling edge until dec_start rises.
  task automatic wait_start(input bit inject, output int cycles);
    cycles = -1;
    for (int j = 0; j < 300; j++) begin
      if (dec_start) begin cycles = j; break; end
      idle();
      if (inject && j == 10) begin
        mem_1_w_enable = 1'b1; llr_mem_w_addr = 7'd127; mem_llr_slct = 2'd0; llrs = 8'sd77;
      end
      @(negedge clk);
    end
    idle();
    if (cycles >= 0) apply_combine();
    chk("start_latency", 32'(cycles), 32'd89);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_rd_data", dec_rd_data, 32'h0);
    chk("rst_rd_vld", 32'(dec_rd_vld), 32'd0);
    chk("rst_dec_start", 32'(dec_start), 32'd0);
    chk("rst_buf_ready", 32'(buf_ready), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reads while filling are ignored
    dec_rd_en = 1'b1; dec_rd_addr = 7'd5;
    @(negedge clk);
    chk("fill_rd_ignored", 32'(dec_rd_vld), 32'd0);
    idle();

    // Frame 1: bank1 word k = {k,k,k,k}, bank2 all ones; llr_done on last write
    for (int k = 0; k < 128; k++)
      for (int l = 0; l < 4; l++) wr(1, 0, k, l, k, 0);
    for (int k = 0; k < 88; k++)
      for (int l = 0; l < 4; l++) wr(0, 1, k, l, 1, (k == 87 && l == 3));
    wait_start(1, n);
    chk("combine_ready_at_start", 32'(buf_ready), 32'd1);
    rd(5);
    chk("dec_start_pulse", 32'(dec_start), 32'd0);
    rd(100); rd(127); rd(87); rd(88); rd(0);
    idle();
    @(negedge clk);
    chk("wr_err_combine", 32'(wr_err), 32'd1);

    // llr_done in READY is ignored
    llr_done = 1'b1;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("done_in_ready_ignored", 32'(buf_ready), 32'd1);

    // Frame 2: first write in READY restarts; zero fill, lane isolation, saturation
    wr(1, 1, 0, 0, 0, 0);
    chk("ready_to_fill", 32'(buf_ready), 32'd0);
    for (int k = 0; k < 128; k++)
      for (int l = 0; l < 4; l++) wr(1, k < 88, k, l, 0, 0);
    wr(1, 0, 3, 2, 'h55, 0);
    wr(1, 0, 0, 0, 100, 0); wr(1, 0, 0, 1, -100, 0);
    wr(1, 0, 0, 2, 127, 0); wr(1, 0, 0, 3, -127, 0);
    wr(0, 1, 0, 0, 100, 0); wr(0, 1, 0, 1, -100, 0);
    wr(0, 1, 0, 2, 1, 0);   wr(0, 1, 0, 3, -1, 1);
    wait_start(0, n);
    rd(0); rd(3); rd(1); rd(127);
    idle();

    // Abort a combine with reset at cnt=40
    wr(1, 0, 0, 0, 5, 0);
    wr(0, 0, 0, 0, 0, 1);
    idle();
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_dec_start", 32'(dec_start), 32'd0);
    chk("midrst_buf_ready", 32'(buf_ready), 32'd0);
    chk("midrst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Out-of-range bank2 write is flagged
    wr(0, 1, 100, 0, 9, 0);
    idle();
    @(negedge clk);
    chk("wr_err_bank2_range", 32'(wr_err), 32'd1);

    // Frame 3: full refill with saturating repeats, full-length combine
    for (int k = 0; k < 128; k++)
      for (int l = 0; l < 4; l++)
        wr(1, k < 88, k, l, ((k * 7 + l * 13) % 256) - 128, (k == 127 && l == 3));
    wait_start(0, n);
    rd(0); rd(3); rd(50); rd(87); rd(88); rd(127);
    idle();
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
